// File: rtl/alu_packet_ctrl.sv
// ============================================================================
// Module  : alu_packet_ctrl
// Purpose : Parses UART packets and either echoes the payload or feeds 32-bit
//           operands to the ALU and returns the 32-bit result on TX.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_packet_ctrl #(
    parameter logic [7:0] ECHO_OP = 8'hEC,
    parameter logic [7:0] ADD_OP  = 8'hA0,
    parameter logic [7:0] MUL_OP  = 8'hA1,
    parameter logic [7:0] DIV_OP  = 8'hA2
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [1:0]  alu_op_o,
    output logic [31:0] alu_operand_o,
    output logic        alu_first_o,
    output logic        alu_last_o,
    output logic        alu_valid_o,
    input  logic        alu_ready_i,
    input  logic [31:0] alu_result_i,
    input  logic        alu_result_valid_i,
    output logic        err_o
);

    localparam logic [3:0] S_OPCODE  = 4'd0;
    localparam logic [3:0] S_RSVD    = 4'd1;
    localparam logic [3:0] S_LENLO   = 4'd2;
    localparam logic [3:0] S_LENHI   = 4'd3;
    localparam logic [3:0] S_ECHO    = 4'd4;
    localparam logic [3:0] S_OPERAND = 4'd5;
    localparam logic [3:0] S_ISSUE   = 4'd6;
    localparam logic [3:0] S_WAIT    = 4'd7;
    localparam logic [3:0] S_SEND    = 4'd8;
    localparam logic [3:0] S_DRAIN   = 4'd9;

    logic [3:0]  state_q,    state_d;
    logic [7:0]  opcode_q,   opcode_d;
    logic [7:0]  len_lo_q,   len_lo_d;
    logic [15:0] rem_q,      rem_d;
    logic [31:0] operand_q,  operand_d;
    logic [31:0] result_q,   result_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        first_q,    first_d;
    logic        err_q,      err_d;
    logic [1:0]  alu_op_q,   alu_op_d;

    logic [15:0] w_len;
    logic [15:0] w_rem;
    logic        w_arith_ok;

    assign w_len = {rx_data_i, len_lo_q};
    assign w_rem = w_len - 16'd4;
    assign w_arith_ok = (((opcode_q == ADD_OP) || (opcode_q == MUL_OP)) &&
                         (w_rem != 16'd0) && (w_rem[1:0] == 2'b00)) ||
                        ((opcode_q == DIV_OP) && (w_rem == 16'd8));

    assign alu_operand_o = operand_q;
    assign alu_op_o      = alu_op_q;
    assign err_o         = err_q;

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        len_lo_d    = len_lo_q;
        rem_d       = rem_q;
        operand_d   = operand_q;
        result_d    = result_q;
        byte_cnt_d  = byte_cnt_q;
        first_d     = first_q;
        err_d       = 1'b0;
        alu_op_d    = alu_op_q;
        rx_ready_o  = 1'b0;
        tx_valid_o  = 1'b0;
        tx_data_o   = 8'h00;
        alu_valid_o = 1'b0;
        alu_first_o = 1'b0;
        alu_last_o  = 1'b0;

        case (state_q)
            S_OPCODE: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
                    opcode_d = rx_data_i;
                    state_d  = S_RSVD;
                end
            end
            S_RSVD: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) state_d = S_LENLO;
            end
            S_LENLO: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
                    len_lo_d = rx_data_i;
                    state_d  = S_LENHI;
                end
            end
            S_LENHI: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
                    if (w_len < 16'd4) begin
                        err_d   = 1'b1;
                        state_d = S_OPCODE;
                    end else if (opcode_q == ECHO_OP) begin
                        rem_d   = w_rem;
                        state_d = (w_rem == 16'd0) ? S_OPCODE : S_ECHO;
                    end else if (w_arith_ok) begin
                        rem_d      = w_rem;
                        first_d    = 1'b1;
                        byte_cnt_d = 2'd0;
                        alu_op_d   = (opcode_q == MUL_OP) ? 2'd1 :
                                     (opcode_q == DIV_OP) ? 2'd2 : 2'd0;
                        state_d    = S_OPERAND;
                    end else begin
                        rem_d   = w_rem;
                        err_d   = 1'b1;
                        state_d = (w_rem == 16'd0) ? S_OPCODE : S_DRAIN;
                    end
                end
            end
            S_ECHO: begin
                // Straight wire-through so echo adds no latency and no buffering
                tx_data_o  = rx_data_i;
                tx_valid_o = rx_valid_i;
                rx_ready_o = tx_ready_i;
                if (rx_valid_i && tx_ready_i) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = S_OPCODE;
                end
            end
            S_OPERAND: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
                    operand_d  = {rx_data_i, operand_q[31:8]};
                    rem_d      = rem_q - 16'd1;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                alu_valid_o = 1'b1;
                alu_first_o = first_q;
                alu_last_o  = (rem_q == 16'd0);
                if (alu_ready_i) begin
                    first_d = 1'b0;
                    state_d = (rem_q == 16'd0) ? S_WAIT : S_OPERAND;
                end
            end
            S_WAIT: begin
                if (alu_result_valid_i) begin
                    result_d   = alu_result_i;
                    byte_cnt_d = 2'd0;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                tx_valid_o = 1'b1;
                tx_data_o  = result_q[{byte_cnt_q, 3'b000} +: 8];
                if (tx_ready_i) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) state_d = S_OPCODE;
                end
            end
            S_DRAIN: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = S_OPCODE;
                end
            end
            default: state_d = S_OPCODE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_OPCODE;
            opcode_q   <= 8'h00;
            len_lo_q   <= 8'h00;
            rem_q      <= 16'h0000;
            operand_q  <= 32'h0;
            result_q   <= 32'h0;
            byte_cnt_q <= 2'd0;
            first_q    <= 1'b0;
            err_q      <= 1'b0;
            alu_op_q   <= 2'd0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            len_lo_q   <= len_lo_d;
            rem_q      <= rem_d;
            operand_q  <= operand_d;
            result_q   <= result_d;
            byte_cnt_q <= byte_cnt_d;
            first_q    <= first_d;
            err_q      <= err_d;
            alu_op_q   <= alu_op_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_packet_ctrl.sv
// ============================================================================
// Module  : tb_alu_packet_ctrl
// Purpose : Directed-vector bench for alu_packet_ctrl with a small ALU model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_packet_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic [1:0]  alu_op_o;
    logic [31:0] alu_operand_o;
    logic        alu_first_o;
    logic        alu_last_o;
    logic        alu_valid_o;
    logic        alu_ready_i = 1'b1;
    logic [31:0] alu_result_i = 32'h0;
    logic        alu_result_valid_i = 1'b0;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    alu_packet_ctrl u_dut (
        .clk_i              (clk_i),
        .reset_ni           (reset_ni),
        .rx_data_i          (rx_data_i),
        .rx_valid_i         (rx_valid_i),
        .rx_ready_o         (rx_ready_o),
        .tx_data_o          (tx_data_o),
        .tx_valid_o         (tx_valid_o),
        .tx_ready_i         (tx_ready_i),
        .alu_op_o           (alu_op_o),
        .alu_operand_o      (alu_operand_o),
        .alu_first_o        (alu_first_o),
        .alu_last_o         (alu_last_o),
        .alu_valid_o        (alu_valid_o),
        .alu_ready_i        (alu_ready_i),
        .alu_result_i       (alu_result_i),
        .alu_result_valid_i (alu_result_valid_i),
        .err_o              (err_o)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [7:0]  tx_q[$];
    logic [7:0]  pkt[$];
    logic [7:0]  exp_b[$];
    logic [35:0] alu_q[$];
    int          rx_acc = 0;
    int          err_cnt = 0;
    int          hold_cnt = 0;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_op = 32'h0;
    logic [31:0] acc = 32'h0;
    int          res_delay = 0;
    logic        tx_rand_en = 1'b0;
    logic        tx_force = 1'b1;
    int          stall_id = 0;
    int          stall_seen = 0;
    int          stall_len = 0;
    int          stall_left = 0;

    // Observe transfers on the rising edge, using pre-edge values
    always @(posedge clk_i) begin
        if (tx_valid_o && tx_ready_i) tx_q.push_back(tx_data_o);
        if (rx_valid_i && rx_ready_o) rx_acc++;
        if (err_o) err_cnt++;
        if (hold_pend) begin
            hold_cnt++;
            check_val("alu_hold_valid", {35'h0, alu_valid_o}, 36'h1);
            check_val("alu_hold_operand", {4'h0, alu_operand_o}, {4'h0, hold_op});
            check_val("alu_hold_rx_ready", {35'h0, rx_ready_o}, 36'h0);
        end
        hold_pend = alu_valid_o && !alu_ready_i;
        hold_op   = alu_operand_o;
        if (alu_valid_o && alu_ready_i) begin
            alu_q.push_back({alu_op_o, alu_first_o, alu_last_o, alu_operand_o});
            if (alu_first_o) acc = alu_operand_o;
            else begin
                case (alu_op_o)
                    2'd0:    acc = acc + alu_operand_o;
                    2'd1:    acc = acc * alu_operand_o;
                    default: acc = (alu_operand_o == 32'h0) ? 32'hFFFF_FFFF : acc / alu_operand_o;
                endcase
            end
            if (alu_last_o) res_delay = 4;
        end else if (res_delay != 0) begin
            res_delay--;
        end
    end

    always @(negedge clk_i) tx_ready_i = tx_rand_en ? 1'($urandom_range(0, 1)) : tx_force;

    always @(negedge clk_i) begin
        if (stall_id != stall_seen) begin
            stall_seen = stall_id;
            stall_left = stall_len;
        end
        if (alu_valid_o && stall_left != 0) begin
            alu_ready_i = 1'b0;
            stall_left--;
        end else begin
            alu_ready_i = 1'b1;
        end
    end

    always @(negedge clk_i) begin
        alu_result_valid_i = (res_delay == 1);
        alu_result_i       = (res_delay == 1) ? acc : 32'h0;
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        #1;
        while (!rx_ready_o && n < 100) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        if (!rx_ready_o) check_val("rx_accept", {35'h0, rx_ready_o}, 36'h1);
        @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) send_byte(pkt[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wait_tx(input int n);
        for (int k = 0; k < 300 && tx_q.size() < n; k++) @(negedge clk_i);
    endtask

    task automatic wait_tx_valid();
        for (int k = 0; k < 60 && !tx_valid_o; k++) @(negedge clk_i);
    endtask

    task automatic expect_tx(input string tag);
        logic [7:0] got;
        check_val({tag, "_count"}, 36'(tx_q.size()), 36'(exp_b.size()));
        foreach (exp_b[i]) begin
            got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
            check_val({tag, "_byte"}, {28'h0, got}, {28'h0, exp_b[i]});
        end
        tx_q.delete();
    endtask

    int e0, a0, h0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk_i);
        #1;
        check_val("rst_rx_ready", {35'h0, rx_ready_o}, 36'h1);
        check_val("rst_tx_valid", {35'h0, tx_valid_o}, 36'h0);
        check_val("rst_tx_data", {28'h0, tx_data_o}, 36'h0);
        check_val("rst_alu_valid", {35'h0, alu_valid_o}, 36'h0);
        check_val("rst_alu_flags", {34'h0, alu_first_o, alu_last_o}, 36'h0);
        check_val("rst_alu_op", {34'h0, alu_op_o}, 36'h0);
        check_val("rst_operand", {4'h0, alu_operand_o}, 36'h0);
        check_val("rst_err", {35'h0, err_o}, 36'h0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        idle(2);

        // Echo, with rx_ready following tx_ready
        pkt = '{8'hEC, 8'h00, 8'h07, 8'h00};
        send_pkt();
        tx_force = 1'b0;
        @(negedge clk_i);
        rx_data_i  = 8'h41;
        rx_valid_i = 1'b1;
        #1;
        check_val("echo_rdy_low", {35'h0, rx_ready_o}, 36'h0);
        check_val("echo_tx_valid", {35'h0, tx_valid_o}, 36'h1);
        check_val("echo_tx_data", {28'h0, tx_data_o}, 36'h41);
        tx_force = 1'b1;
        @(negedge clk_i);
        #1;
        check_val("echo_rdy_high", {35'h0, rx_ready_o}, 36'h1);
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        pkt = '{8'h42, 8'h43};
        send_pkt();
        idle(3);
        exp_b = '{8'h41, 8'h42, 8'h43};
        expect_tx("echo");
        check_val("echo_no_err", 36'(err_cnt), 36'h0);

        // Echo under random TX stalls
        tx_rand_en = 1'b1;
        pkt = '{8'hEC, 8'h00, 8'h0A, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_pkt();
        tx_rand_en = 1'b0;
        idle(3);
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        expect_tx("echo_stall");

        // Add of two operands
        alu_q.delete();
        pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_tx(4);
        exp_b = '{8'h03, 8'h00, 8'h00, 8'h00};
        expect_tx("add");
        check_val("add_alu_cnt", 36'(alu_q.size()), 36'd2);
        check_val("add_alu0", alu_q.size() > 0 ? alu_q[0] : 36'hx, {2'd0, 1'b1, 1'b0, 32'h1});
        check_val("add_alu1", alu_q.size() > 1 ? alu_q[1] : 36'hx, {2'd0, 1'b0, 1'b1, 32'h2});

        // Multiply
        alu_q.delete();
        pkt = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_tx(4);
        exp_b = '{8'h0F, 8'h00, 8'h00, 8'h00};
        expect_tx("mul");
        check_val("mul_alu0", alu_q.size() > 0 ? alu_q[0] : 36'hx, {2'd1, 1'b1, 1'b0, 32'h3});
        check_val("mul_alu1", alu_q.size() > 1 ? alu_q[1] : 36'hx, {2'd1, 1'b0, 1'b1, 32'h5});

        // Divide with 5 cycles of ALU backpressure on the first operand
        alu_q.delete();
        h0 = hold_cnt;
        stall_len = 5;
        stall_id++;
        pkt = '{8'hA2, 8'h00, 8'h0C, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_tx(4);
        exp_b = '{8'h0E, 8'h00, 8'h00, 8'h00};
        expect_tx("div");
        check_val("div_stall_cycles", 36'(hold_cnt - h0), 36'd5);
        check_val("div_alu0", alu_q.size() > 0 ? alu_q[0] : 36'hx, {2'd2, 1'b1, 1'b0, 32'h64});
        check_val("div_alu1", alu_q.size() > 1 ? alu_q[1] : 36'hx, {2'd2, 1'b0, 1'b1, 32'h7});

        // Div with a single operand: error and drain 4 bytes
        e0 = err_cnt;
        a0 = rx_acc;
        pkt = '{8'hA2, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        send_pkt();
        idle(3);
        check_val("div1_err", 36'(err_cnt - e0), 36'd1);
        check_val("div1_rx_count", 36'(rx_acc - a0), 36'd8);
        check_val("div1_no_tx", 36'(tx_q.size()), 36'd0);

        // Unknown opcode, LEN=6: err pulse right after LenHi accept
        e0 = err_cnt;
        pkt = '{8'h55, 8'h00, 8'h06};
        send_pkt();
        send_byte(8'h00);
        #1;
        check_val("unk_err_pulse", {35'h0, err_o}, 36'h1);
        check_val("unk_no_tx", {35'h0, tx_valid_o}, 36'h0);
        pkt = '{8'hAA, 8'hBB};
        send_pkt();
        idle(2);
        #1;
        check_val("unk_err_count", 36'(err_cnt - e0), 36'd1);
        check_val("unk_idle_ready", {35'h0, rx_ready_o}, 36'h1);

        // LEN=2: next byte is an opcode again
        e0 = err_cnt;
        pkt = '{8'hEC, 8'h00, 8'h02, 8'h00, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
        send_pkt();
        idle(3);
        check_val("len2_err", 36'(err_cnt - e0), 36'd1);
        exp_b = '{8'h5A};
        expect_tx("len2_echo");

        // Back-to-back echo then add, with TX stalled during Send
        alu_q.delete();
        pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h77};
        send_pkt();
        tx_force = 1'b0;
        pkt = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_tx_valid();
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val("b2b_send_valid", {35'h0, tx_valid_o}, 36'h1);
            check_val("b2b_send_data", {28'h0, tx_data_o}, 36'h05);
            check_val("b2b_rx_blocked", {35'h0, rx_ready_o}, 36'h0);
            @(negedge clk_i);
        end
        tx_force = 1'b1;
        wait_tx(5);
        exp_b = '{8'h77, 8'h05, 8'h00, 8'h00, 8'h00};
        expect_tx("b2b");
        check_val("b2b_alu0", alu_q.size() > 0 ? alu_q[0] : 36'hx, {2'd0, 1'b1, 1'b1, 32'h5});

        // Asynchronous reset while in Operand
        pkt = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02};
        send_pkt();
        #2;
        reset_ni = 1'b0;
        #1;
        check_val("rstop_rx_ready", {35'h0, rx_ready_o}, 36'h1);
        check_val("rstop_operand", {4'h0, alu_operand_o}, 36'h0);
        check_val("rstop_alu_op", {34'h0, alu_op_o}, 36'h0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        idle(1);

        // Asynchronous reset while in Send
        e0 = err_cnt;
        tx_force = 1'b0;
        pkt = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_tx_valid();
        #1;
        check_val("rstsend_reached", {35'h0, tx_valid_o}, 36'h1);
        #1;
        reset_ni = 1'b0;
        #1;
        check_val("rstsend_tx_valid", {35'h0, tx_valid_o}, 36'h0);
        check_val("rstsend_tx_data", {28'h0, tx_data_o}, 36'h0);
        check_val("rstsend_rx_ready", {35'h0, rx_ready_o}, 36'h1);
        @(negedge clk_i);
        reset_ni = 1'b1;
        tx_force = 1'b1;
        idle(4);
        check_val("rstsend_no_tx", 36'(tx_q.size()), 36'd0);
        check_val("rstsend_no_err", 36'(err_cnt - e0), 36'd0);

        // Fresh echo after reset
        pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'hAB, 8'hCD};
        send_pkt();
        idle(3);
        exp_b = '{8'hAB, 8'hCD};
        expect_tx("post_rst_echo");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
